// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Frame states, legal prescale values and the parity helper.
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic prescale_ok(
    input logic [5:0] p
  );
    return (p == PRESCALE_8) ||
           (p == PRESCALE_16) ||
           (p == PRESCALE_32);
  endfunction

  function automatic logic exp_parity(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and bit counter for the UART receiver.
// edge_cnt wraps at prescale-1; each wrap advances bit_cnt.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic [5:0] i_prescale,
  output logic [5:0] o_edge_cnt,
  output logic [3:0] o_bit_cnt
);

  logic [5:0] r_edge;
  logic [3:0] r_bit;
  logic       w_wrap;

  assign w_wrap = (r_edge == (i_prescale - 6'd1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (i_clear) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (i_enable) begin
      if (w_wrap) begin
        r_edge <= '0;
        r_bit  <= r_bit + 4'd1;
      end else begin
        r_edge <= r_edge + 6'd1;
      end
    end
  end

  assign o_edge_cnt = r_edge;
  assign o_bit_cnt  = r_bit;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing
// around the external majority-vote sampler.
module uart_rx_ctrl
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic [5:0]            edge_cnt,
  output logic                  dat_samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  state_t r_state;
  state_t w_next;

  logic [5:0]            r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_dv;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic [3:0] w_bit_cnt;
  logic       w_busy;
  logic       w_bit_end;
  logic       w_start;
  logic       w_exp_par;

  assign w_busy    = (r_state != IDLE);
  assign w_bit_end = (edge_cnt == (r_prescale - 6'd1));
  assign w_start   = (r_state == IDLE) && !RX_IN;
  assign w_exp_par = exp_parity(r_shift, r_par_typ);

  uart_rx_edge_bit_counter u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .i_enable   (w_busy),
    .i_clear    (!w_busy),
    .i_prescale (r_prescale),
    .o_edge_cnt (edge_cnt),
    .o_bit_cnt  (w_bit_cnt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (!RX_IN) w_next = START;
      end
      START: begin
        if (w_bit_end)
          w_next = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (w_bit_end && (w_bit_cnt == 4'd8))
          w_next = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (w_bit_end) w_next = STOP;
      end
      STOP: begin
        if (w_bit_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // An illegal prescale falls back to 16 so the counter always wraps.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_prescale <= PRESCALE_16;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_shift    <= '0;
      r_pdata    <= '0;
      r_dv       <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      if (w_start) begin
        r_prescale <= prescale_ok(prescale) ? prescale : PRESCALE_16;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_err  <= 1'b0;
        r_stp_err  <= 1'b0;
      end
      if ((r_state == DATA) && w_bit_end)
        r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
      if ((r_state == PARITY) && w_bit_end)
        r_par_err <= (sampled_bit != w_exp_par);
      if ((r_state == STOP) && w_bit_end) begin
        r_stp_err <= ~sampled_bit;
        if (sampled_bit && !r_par_err) begin
          r_pdata <= r_shift;
          r_dv    <= 1'b1;
        end
      end
    end
  end

  assign dat_samp_en = w_busy;
  assign busy        = w_busy;
  assign P_DATA      = r_pdata;
  assign data_valid  = r_dv;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame controller for the UART receiver. It runs the oversampling edge counter and the bit counter, and enables and paces the 3-sample majority-vote sampler (data_sampling). It consumes the voted `sampled_bit` to validate the start bit, deserialize 8 data bits LSB-first, check optional parity and check the stop bit. It sits between the RX pin synchronizer and the RX-side data synchronizer, in the UART_RX clock domain.

## Interface
- No parameters. Data width is fixed at 8. Prescale is a run-time input.
- CLK  in  1  UART RX oversampling clock
- RST  in  1  reset RST, asynchronous, active-low
- RX_IN  in  1  serial line, already synchronized; idle high
- prescale  in  6  oversampling ratio; legal values 8, 16, 32
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- sampled_bit  in  1  voted bit from data_sampling
- edge_cnt  out  6  oversample index within the current bit, 0..prescale-1; drives data_sampling
- dat_samp_en  out  1  sampler enable; high in every non-IDLE state
- P_DATA  out  8  last accepted byte
- data_valid  out  1  one-cycle pulse when P_DATA is updated
- par_err  out  1  parity error flag for the last frame
- stp_err  out  1  stop-bit error flag for the last frame
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Bit-end cycle: the cycle with edge_cnt == prescale-1. All decisions are taken here, because sampled_bit is stable from edge prescale/2+3 onward. This is why prescale must be at least 8.
- IDLE:
  - edge_cnt and bit_cnt are held at 0.
  - RX_IN == 0 moves to START.
  - On that move, prescale, PAR_EN and PAR_TYP are latched, and par_err and stp_err are cleared.
- START: at bit-end, sampled_bit == 0 moves to DATA. Otherwise it is a glitch: go to IDLE with no flags and no data_valid.
- DATA:
  - At each bit-end, sampled_bit is shifted into the internal shift register from the MSB side, shifting right.
  - After the 8th data bit, go to PARITY if PAR_EN latched high, else STOP.
- PARITY:
  - Expected parity = XOR of the 8 data bits, inverted if PAR_TYP = 1.
  - At bit-end, par_err <= (sampled_bit != expected), then go to STOP.
- STOP:
  - At bit-end, stp_err <= ~sampled_bit.
  - If there is no stop error and no parity error, P_DATA <= shift register and data_valid pulses.
  - Always return to IDLE.
- Counters:
  - edge_cnt increments each cycle while busy and wraps prescale-1 -> 0.
  - bit_cnt (4-bit, internal) increments on each wrap and clears on return to IDLE.
- Errors: P_DATA holds its previous value on any error. par_err and stp_err stay held until the next frame starts.
- Changes to prescale, PAR_EN or PAR_TYP mid-frame are ignored until the next IDLE -> START.
- Behaviour with an illegal prescale value is undefined.

## Timing
- Reset values: state IDLE, edge_cnt 0, dat_samp_en 0, P_DATA 0x00, data_valid 0, par_err 0, stp_err 0, busy 0. Shift register and bit_cnt are 0.
- Reset asserted mid-frame aborts immediately. No data_valid is produced for the partial frame.
- The first START cycle has edge_cnt = 0. A frame occupies (10 + PAR_EN) × prescale cycles, plus one IDLE detection cycle.
- data_valid, P_DATA, par_err and stp_err update on the clock edge ending the STOP bit-end cycle. data_valid is high for exactly one cycle.
- Back-to-back frames: the controller is in IDLE the cycle after STOP, so a start bit beginning right after the stop bit is caught with a one-cycle detection delay.
- RX_IN low while in STOP does not start a new frame early.

## Structure
- Shared package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding
  - prescale constants PRESCALE_8/16/32
  - DATA_WIDTH = 8
- Sub-module uart_rx_edge_bit_counter holds edge_cnt and bit_cnt, with inputs enable, clear and prescale.
- FSM, shift register, parity and stop checks stay in uart_rx_ctrl.

## Test plan
- Prescale 8, PAR_EN 0, byte 0xA5 (LSB-first) with stop bit 1 -> data_valid pulses once, P_DATA = 0xA5, both flags 0, 80 cycles after detection.
- Prescale 16, PAR_EN 1, PAR_TYP 0, byte 0x37 with parity bit 1 -> P_DATA = 0x37, par_err 0. Repeat with parity bit 0 -> par_err 1, no data_valid, P_DATA unchanged.
- Prescale 32, PAR_TYP 1, byte 0x00 with stop bit 0 -> stp_err 1, no data_valid. The next good frame 0xFF clears both flags and outputs 0xFF.
- RX_IN low for 3 cycles then high (prescale 16) -> START rejected at bit-end, return to IDLE, no flags, busy drops.
- Back-to-back frames 0x12 then 0x34 with no idle gap (prescale 8) -> two data_valid pulses, P_DATA 0x12 then 0x34.
- RST asserted during DATA bit 4 of 0x5A -> all outputs at reset values. The next full frame 0x5A is received correctly.
